seg7_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller for the 4-digit 7-segment display.
- Drives the 2-bit digit select SW into the existing 4:1 digit selector and reads back the selected 4-bit CNT.
- Generates the one-hot anode enables, with a blanking gap between digits (anti-ghosting) and optional leading-zero blanking.
- Sits between the counter/selector datapath and the board pins.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_prescaler.sv | 36 +++
 rtl/seg7_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 4-digit 7-segment scan controller.
//   state_t  : scan FSM states (IDLE, BLANKING, SHOW)
//   SEL_MSD  : digit select of the most significant digit (scan starts here)
//   SEL_LSD  : digit select of the least significant digit (scan ends here)
//   onehot4  : anode pattern for one digit, honouring anode polarity
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BLANKING = 2'd1,
    SHOW     = 2'd2
  } state_t;

  localparam logic [1:0] SEL_MSD = 2'b11;
  localparam logic [1:0] SEL_LSD = 2'b00;

  // Anode pattern with only the bit for 'sel' enabled. For active-low anodes
  // the enabled bit is the single 0.
  function automatic logic [3:0] onehot4(input logic [1:0] sel,
                                         input logic       active_low);
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// -----------------------------------------------------------------------------
// seg7_prescaler
// Terminal-count counter shared by the BLANKING and SHOW phases. It counts
// 0..term and wraps to 0 by itself, so consecutive phases chain without an
// explicit reload; the owner only swaps 'term' when the phase changes.
//   clk   : system clock
//   rst   : synchronous active-high reset (count -> 0)
//   clear : hold the count at 0 (scanner idle)
//   term  : last count value of the current phase
//   tc    : high in the cycle the count equals term (and not cleared)
// -----------------------------------------------------------------------------
module seg7_prescaler #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count_reg;

  assign tc = !clear && (count_reg == term);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (count_reg == term) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexing scan controller for a 4-digit 7-segment display. Walks the
// digit select from the most to the least significant digit, lighting each
// digit for DIV cycles after a dark gap of BLANK cycles, with optional
// leading-zero blanking.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   en    : scan enable; 0 forces the display dark and restarts the scan
//   lzb   : leading-zero blanking enable
//   cnt   : digit value returned by the external selector for 'sw'
//   sw    : digit select driven to the external selector (3 = MSD)
//   an    : anode enables, an[i] belongs to sw == i
//   frame : one-cycle pulse in the cycle sw wraps from 0 back to 3
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV           = 50000,
  parameter int BLANK         = 500,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lzb,
  input  logic [3:0] cnt,
  output logic [1:0] sw,
  output logic [3:0] an,
  output logic       frame
);

  localparam int MAX_LEN = (DIV > BLANK) ? ((DIV > 2) ? DIV : 2)
                                         : ((BLANK > 2) ? BLANK : 2);
  localparam int PW = $clog2(MAX_LEN);

  localparam logic          AL       = (AN_ACTIVE_LOW != 0);
  localparam logic [3:0]    AN_OFF   = AL ? 4'hF : 4'h0;
  localparam logic [PW-1:0] DIV_TC   = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_TC = PW'((BLANK > 0) ? BLANK - 1 : 0);

  state_t     state_reg;
  logic [1:0] sw_reg;
  logic [3:0] an_reg;
  logic       frame_reg;
  logic       zr_reg;     // no digit lit yet in this frame

  logic          ps_clear;
  logic          ps_tc;
  logic [PW-1:0] ps_term;

  assign ps_clear = !en || (state_reg == IDLE);
  assign ps_term  = (state_reg == SHOW) ? DIV_TC : BLANK_TC;

  seg7_prescaler #(
    .W (PW)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (ps_clear),
    .term  (ps_term),
    .tc    (ps_tc)
  );

  // Decision taken on entry to SHOW. Normally the digit being entered is the
  // current sw (coming from IDLE or BLANKING). Without a BLANKING phase the
  // entry happens from SHOW, so the digit is the next one and the zero-run
  // flag re-arms first if this is the wrap. In that case cnt still reflects
  // the previous select, as there was no settled cycle to read it.
  logic [1:0] entry_sel;
  logic       entry_zr;
  logic       entry_lit;
  logic [3:0] entry_an;
  logic       entry_zr_next;

  always_comb begin
    entry_sel = sw_reg;
    entry_zr  = zr_reg;
    if (state_reg == SHOW) begin
      entry_sel = sw_reg - 2'd1;
      if (sw_reg == SEL_LSD) begin
        entry_zr = 1'b1;
      end
    end
    // The least significant digit is never suppressed.
    entry_lit     = !(lzb && entry_zr && (cnt == 4'd0) && (entry_sel != SEL_LSD));
    entry_an      = entry_lit ? onehot4(entry_sel, AL) : AN_OFF;
    entry_zr_next = entry_zr && !entry_lit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sw_reg    <= SEL_MSD;
      an_reg    <= AN_OFF;
      frame_reg <= 1'b0;
      zr_reg    <= 1'b1;
    end else begin
      frame_reg <= 1'b0;
      if (!en) begin
        // Abandon any partial frame; no frame pulse.
        state_reg <= IDLE;
        sw_reg    <= SEL_MSD;
        an_reg    <= AN_OFF;
        zr_reg    <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (BLANK == 0) begin
              state_reg <= SHOW;
              an_reg    <= entry_an;
              zr_reg    <= entry_zr_next;
            end else begin
              state_reg <= BLANKING;
            end
          end

          BLANKING: begin
            if (ps_tc) begin
              state_reg <= SHOW;
              an_reg    <= entry_an;
              zr_reg    <= entry_zr_next;
            end
          end

          SHOW: begin
            if (ps_tc) begin
              sw_reg <= sw_reg - 2'd1;
              if (sw_reg == SEL_LSD) begin
                frame_reg <= 1'b1;
                zr_reg    <= 1'b1;
              end
              if (BLANK == 0) begin
                an_reg <= entry_an;
                zr_reg <= entry_zr_next;
              end else begin
                // Anodes go dark in the same cycle sw moves on.
                state_reg <= BLANKING;
                an_reg    <= AN_OFF;
              end
            end
          end

          default: begin
            state_reg <= IDLE;
            sw_reg    <= SEL_MSD;
            an_reg    <= AN_OFF;
            zr_reg    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sw    = sw_reg;
  assign an    = an_reg;
  assign frame = frame_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Two scan controllers run side by side from the same enable/reset and the same
// digit values: 'a' with DIV=4, BLANK=2, active-low anodes and leading-zero
// blanking; 'b' with DIV=1, BLANK=0, active-high anodes. Expected outputs come
// from a timeline model: cycles since scan start -> slot, position in slot,
// frame boundary, with the lit/dark decision taken per digit on SHOW entry.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int DIV_A = 4;
  localparam int BLANK_A = 2;
  localparam int DIV_B = 1;
  localparam int BLANK_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, lzb;
  logic [3:0] vals [4];
  logic [1:0] sw_a, sw_b;
  logic [3:0] an_a, an_b, cnt_a, cnt_b;
  logic       frame_a, frame_b;

  // Behavioural stand-in for the external 4:1 digit selector.
  assign cnt_a = vals[sw_a];
  assign cnt_b = vals[sw_b];

  seg7_scan_ctrl #(.DIV(DIV_A), .BLANK(BLANK_A), .AN_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .lzb(lzb), .cnt(cnt_a),
    .sw(sw_a), .an(an_a), .frame(frame_a)
  );

  seg7_scan_ctrl #(.DIV(DIV_B), .BLANK(BLANK_B), .AN_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .lzb(1'b0), .cnt(cnt_b),
    .sw(sw_b), .an(an_b), .frame(frame_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state, index 0 = dut_a, 1 = dut_b.
  int div_m   [2] = '{DIV_A, DIV_B};
  int blank_m [2] = '{BLANK_A, BLANK_B};
  bit al_m    [2] = '{1'b1, 1'b0};
  bit run_m   [2];
  int k_m     [2];
  bit lit_m   [2];
  bit anylit_m[2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Advance the model across one clock edge given the inputs sampled there.
  task automatic model_edge(input int m, input bit r, input bit e, input bit l);
    int s;
    int digit;
    s = blank_m[m] + div_m[m];
    if (r || !e) begin
      run_m[m]    = 1'b0;
      k_m[m]      = 0;
      lit_m[m]    = 1'b0;
      anylit_m[m] = 1'b0;
    end else begin
      if (!run_m[m]) begin
        run_m[m] = 1'b1;
        k_m[m]   = 0;
      end else begin
        k_m[m]++;
      end
      if ((k_m[m] % s) == blank_m[m]) begin
        digit = 3 - ((k_m[m] / s) % 4);
        if (digit == 3) anylit_m[m] = 1'b0;
        lit_m[m] = (digit == 0) || !l || (vals[digit] != 4'd0) || anylit_m[m];
        if (lit_m[m]) anylit_m[m] = 1'b1;
      end
    end
  endtask

  task automatic model_out(input int m, output logic [1:0] esw,
                           output logic [3:0] ean, output logic efr);
    int s;
    int pos;
    int slot;
    logic [3:0] off;
    logic [3:0] mask;
    s   = blank_m[m] + div_m[m];
    off = al_m[m] ? 4'hF : 4'h0;
    if (!run_m[m]) begin
      esw = 2'd3;
      ean = off;
      efr = 1'b0;
    end else begin
      pos  = k_m[m] % s;
      slot = (k_m[m] / s) % 4;
      esw  = 2'(3 - slot);
      mask = 4'b0001 << esw;
      ean  = (pos >= blank_m[m] && lit_m[m]) ? (off ^ mask) : off;
      efr  = (k_m[m] > 0) && ((k_m[m] % (4 * s)) == 0);
    end
  endtask

  task automatic step();
    logic [1:0] esw;
    logic [3:0] ean;
    logic       efr;
    @(posedge clk);
    model_edge(0, rst, en, lzb);
    model_edge(1, rst, en, 1'b0);
    #1;
    cyc++;
    model_out(0, esw, ean, efr);
    check("sw_a", 8'(sw_a), 8'(esw));
    check("an_a", 8'(an_a), 8'(ean));
    check("frame_a", 8'(frame_a), 8'(efr));
    check("multihot_a", 8'($countones(~an_a) > 1), 8'd0);
    model_out(1, esw, ean, efr);
    check("sw_b", 8'(sw_b), 8'(esw));
    check("an_b", 8'(an_b), 8'(ean));
    check("frame_b", 8'(frame_b), 8'(efr));
    check("multihot_b", 8'($countones(an_b) > 1), 8'd0);
  endtask

  task automatic set_vals(input logic [3:0] v3, input logic [3:0] v2,
                          input logic [3:0] v1, input logic [3:0] v0);
    vals[3] = v3;
    vals[2] = v2;
    vals[1] = v1;
    vals[0] = v0;
  endtask

  initial begin
    int n;
    // Reset state
    rst = 1'b1;
    en  = 1'b0;
    lzb = 1'b0;
    set_vals(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3) step();

    // Basic scan, no blanking of zeros
    rst = 1'b0;
    en  = 1'b1;
    repeat (60) step();

    // Leading-zero blanking: 0,0,5,0 then all zeros
    lzb = 1'b1;
    set_vals(4'd0, 4'd0, 4'd5, 4'd0);
    repeat (50) step();
    set_vals(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (50) step();

    // LZB raised mid-frame with 0,3,0,0
    lzb = 1'b0;
    set_vals(4'd0, 4'd3, 4'd0, 4'd0);
    n = 0;
    while (frame_a !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("wait_frame", 8'(n < 200), 8'd1);
    repeat (9) step();
    lzb = 1'b1;
    repeat (60) step();

    // EN dropped during digit 1 SHOW, then re-asserted
    lzb = 1'b0;
    n = 0;
    while (!(sw_a == 2'd1 && an_a != 4'hF) && n < 200) begin
      step();
      n++;
    end
    check("wait_dig1", 8'(n < 200), 8'd1);
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (30) step();

    // RST during BLANKING before digit 2
    n = 0;
    while (!(sw_a == 2'd2 && an_a == 4'hF) && n < 200) begin
      step();
      n++;
    end
    check("wait_blank2", 8'(n < 200), 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (30) step();

    // Randomized operation
    for (int i = 0; i < 500; i++) begin
      en  = ($urandom_range(0, 99) >= 2);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) lzb = ~lzb;
      if ($urandom_range(0, 9) == 0) begin
        vals[$urandom_range(0, 3)] = ($urandom_range(0, 2) == 0) ? 4'd0
                                     : 4'($urandom_range(1, 15));
      end
      step();
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
